// File: rtl/riscv_pkg.sv
// Shared sizing for the in-order RISC-V pipeline: datapath width, register-file
// geometry and the pending-write scoreboard counter type.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int SB_W       = 2;

  typedef logic [SB_W-1:0] sb_cnt_t;

endpackage

// File: rtl/opfetch_scoreboard.sv
// Pending-write scoreboard: one saturating-free counter per register plus the
// per-source hazard and bypass-select decisions. Build option: OPFETCH_WB_BYPASS_EN.
module opfetch_scoreboard
  import riscv_pkg::*;
#(
  parameter int SB_W = riscv_pkg::SB_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic                  rd_we,
  input  logic                  issue,
  input  logic                  wb_we,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  output logic                  rs1_hazard,
  output logic                  rs2_hazard,
  output logic                  rd_hazard,
  output logic                  rs1_bypass,
  output logic                  rs2_bypass
);

  logic [SB_W-1:0] cnt [NUM_REGS];
  logic            do_inc;
  logic            do_dec;
  logic            cancel;
  logic [SB_W-1:0] rs1_cnt;
  logic [SB_W-1:0] rs2_cnt;

  assign do_inc = issue && rd_we && (rd != '0);
  assign do_dec = wb_we && (wb_rd != '0) && (cnt[wb_rd] != '0);
  assign cancel = do_inc && do_dec && (rd == wb_rd);

  // A new writer and a retiring writer on the same register cancel out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        cnt[i] <= '0;
      end
    end else if (!cancel) begin
      if (do_inc) begin
        cnt[rd] <= cnt[rd] + SB_W'(1);
      end
      if (do_dec) begin
        cnt[wb_rd] <= cnt[wb_rd] - SB_W'(1);
      end
    end
  end

  assign rs1_cnt = cnt[rs1];
  assign rs2_cnt = cnt[rs2];

  // Only the last outstanding writer can be forwarded; older ones still stall.
  always_comb begin
`ifdef OPFETCH_WB_BYPASS_EN
    rs1_bypass = (rs1 != '0) && (rs1_cnt == SB_W'(1)) && wb_we && (wb_rd == rs1);
    rs2_bypass = (rs2 != '0) && (rs2_cnt == SB_W'(1)) && wb_we && (wb_rd == rs2);
`else
    rs1_bypass = 1'b0;
    rs2_bypass = 1'b0;
`endif
    rs1_hazard = (rs1 != '0) && (rs1_cnt != '0) && !rs1_bypass;
    rs2_hazard = (rs2 != '0) && (rs2_cnt != '0) && !rs2_bypass;
    rd_hazard  = rd_we && (rd != '0) && (cnt[rd] == '1);
  end

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand-fetch stage: owns the integer register file, tracks pending writers and
// hands registered operands to execute. Build option: OPFETCH_WB_BYPASS_EN.
module operand_fetch_stage
  import riscv_pkg::*;
#(
  parameter int XLEN  = riscv_pkg::XLEN,
  parameter int TAG_W = 32,
  parameter int SB_W  = riscv_pkg::SB_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] in_rs1,
  input  logic [REG_ADDR_W-1:0] in_rs2,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_rd_we,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_rs1_data,
  output logic [XLEN-1:0]       out_rs2_data,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_rd_we,
  output logic [TAG_W-1:0]      out_tag,
  input  logic                  wb_we,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]       wb_data
);

  logic [XLEN-1:0] regs [NUM_REGS];
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            rs1_hazard;
  logic            rs2_hazard;
  logic            rd_hazard;
  logic            rs1_bypass;
  logic            rs2_bypass;
  logic            fire;

  opfetch_scoreboard #(
    .SB_W (SB_W)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .rs1        (in_rs1),
    .rs2        (in_rs2),
    .rd         (in_rd),
    .rd_we      (in_rd_we),
    .issue      (fire),
    .wb_we      (wb_we),
    .wb_rd      (wb_rd),
    .rs1_hazard (rs1_hazard),
    .rs2_hazard (rs2_hazard),
    .rd_hazard  (rd_hazard),
    .rs1_bypass (rs1_bypass),
    .rs2_bypass (rs2_bypass)
  );

  // x0 is hardwired to zero, so write-backs to it are dropped here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_we && (wb_rd != '0)) begin
      regs[wb_rd] <= wb_data;
    end
  end

  always_comb begin
    rs1_data = (in_rs1 == '0) ? '0 : regs[in_rs1];
    rs2_data = (in_rs2 == '0) ? '0 : regs[in_rs2];
    if (rs1_bypass) begin
      rs1_data = wb_data;
    end
    if (rs2_bypass) begin
      rs2_data = wb_data;
    end
  end

  assign in_ready = (!out_valid || out_ready) && !(rs1_hazard || rs2_hazard || rd_hazard);
  assign fire     = in_valid && in_ready;

  // Payload only moves on fire, which keeps it frozen under backpressure.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid    <= 1'b0;
      out_rs1_data <= '0;
      out_rs2_data <= '0;
      out_rd       <= '0;
      out_rd_we    <= 1'b0;
      out_tag      <= '0;
    end else if (fire) begin
      out_valid    <= 1'b1;
      out_rs1_data <= rs1_data;
      out_rs2_data <= rs2_data;
      out_rd       <= in_rd;
      out_rd_we    <= in_rd_we;
      out_tag      <= in_tag;
    end else if (out_ready) begin
      out_valid    <= 1'b0;
    end
  end

endmodule

// File: doc/operand_fetch_stage.md
# operand_fetch_stage

Operand-fetch stage and register-file owner for the in-order RISC-V pipeline. It holds the 32-entry integer register file and accepts architectural writes from the write-back stage. It reads rs1/rs2 for the instruction arriving from decode and presents registered operands to execute over a valid/ready handshake. A per-register pending-write scoreboard stalls decode until every source operand is architecturally current.

## Interface
Parameters:
- XLEN, 32, data width
- TAG_W, 32, opaque side-band carried with each instruction (PC, decoded control)
- SB_W, 2, pending-write counter width per register

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- in_valid  in  1  decode offers an instruction
- in_ready  out  1  stage accepts it this cycle
- in_rs1, in_rs2  in  5  source register indices
- in_rd  in  5  destination index
- in_rd_we  in  1  instruction will write in_rd
- in_tag  in  TAG_W  side-band, passed through unchanged
- out_valid  out  1  operands valid toward execute
- out_ready  in  1  execute accepts
- out_rs1_data, out_rs2_data  out  XLEN  operand values
- out_rd  out  5; out_rd_we  out  1; out_tag  out  TAG_W  registered copies
- wb_we  in  1  write-back write enable
- wb_rd  in  5  write-back destination
- wb_data  in  XLEN  write-back value

## Operation
- Register file: 32 x XLEN. x0 reads 0 and is never written; wb_we with wb_rd==0 is ignored.
- Write: on posedge, if wb_we && wb_rd!=0, regs[wb_rd] <= wb_data.
- Scoreboard: cnt[r] of SB_W bits per register, counting issued-but-not-written-back writers.
- Issue: fire = in_valid && in_ready. On fire with in_rd_we && in_rd!=0, cnt[in_rd] is incremented.
- Retire: on wb_we && wb_rd!=0 && cnt[wb_rd]!=0, cnt[wb_rd] is decremented. No underflow: a write-back to a register with cnt 0 updates the register and leaves cnt at 0.
- Simultaneous increment and decrement of the same register leaves cnt unchanged.
- Source hazard for rs (rs!=0, used by both ports):
  - cnt[rs]>1, or
  - cnt[rs]==1 and no bypass is available for that source (see Configuration).
- Destination hazard: in_rd_we && in_rd!=0 && cnt[in_rd]==max (all ones).
- in_ready = (!out_valid || out_ready) && !hazard.
- Output register: on fire, it loads the operands (regfile or bypass), in_rd, in_rd_we and in_tag, and sets out_valid=1.
- When out_valid && out_ready and there is no new fire, out_valid is cleared.
- Outputs hold stable while out_valid && !out_ready.

## Timing
- Reset values: out_valid=0; out_rs1_data, out_rs2_data, out_rd, out_rd_we, out_tag all 0; every cnt=0; every register=0. in_ready is combinational and is 0 only through the hazard or backpressure terms.
- Reset mid-operation clears all scoreboard state. In-flight writers are forgotten and execute must also be reset.
- Latency: operands appear on out_* one cycle after fire.
- Throughput: one instruction per cycle when hazard-free and out_ready=1.
- Reads are combinational from the register file state before the posedge. A same-cycle write-back is visible only through the bypass.
- in_ready combinationally depends on out_ready, in_rs*, in_rd, wb_* and cnt.

## Configuration
- OPFETCH_WB_BYPASS_EN defined:
  - A source with cnt==1, where wb_we && wb_rd==rs in the same cycle, is not a hazard.
  - The operand is taken from wb_data and the instruction issues that cycle.
- Macro undefined:
  - Any cnt[rs]!=0 is a hazard.
  - The instruction issues the cycle after write-back, reading the updated register. This costs one extra stall cycle per RAW dependency.

## Structure
- riscv_pkg: XLEN, REG_ADDR_W=5, NUM_REGS=32, SB_W and the scoreboard counter typedef.
- Sub-module opfetch_scoreboard: cnt array, increment/decrement logic, and the hazard/bypass-select outputs per source. The top level holds the register file, bypass muxes and output register.

## Test plan
- Reset, then wb_we=1, wb_rd=5, wb_data=0xDEADBEEF; next cycle issue rs1=5 -> out_rs1_data=0xDEADBEEF one cycle after fire. Write to x0 -> rs1=0 reads 0.
- Issue rd=3 with we, then rs1=3 -> in_ready=0 until write-back of x3=0x55.
  - With OPFETCH_WB_BYPASS_EN: issues in the write-back cycle with out_rs1_data=0x55.
  - Without the macro: issues one cycle later with the same value.
- Issue two writers to x7 (cnt=2), then a reader of x7 -> stalls through the first write-back and issues only on or after the second, with the second value.
- Issue three writers to x9 (cnt=3) -> a fourth writer to x9 stalls (in_ready=0) until one write-back occurs.
- Hold out_ready=0 with out_valid=1 for 4 cycles -> out_* stable and in_ready=0. Release -> back-to-back issue resumes at one per cycle.
- Assert rst low mid-stall with cnt[4]=1 -> out_valid=0 and all cnt=0. After release, a reader of x4 issues immediately.
